// File: rtl/button_pkg.sv
// button_pkg: shared types and default constants for the push-button
// debounce slice.
//   button_state_t      : debounce FSM state encoding
//   DEBOUNCE_10MS_12MHZ : stable-time qualification, 10 ms at 12 MHz
//   LONG_1S_12MHZ       : long-press hold time, 1 s at 12 MHz
//   PRESS_COUNT_W       : width of the running press counter
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } button_state_t;

  localparam int unsigned DEBOUNCE_10MS_12MHZ = 120000;
  localparam int unsigned LONG_1S_12MHZ       = 12000000;
  localparam int unsigned PRESS_COUNT_W       = 8;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer for asynchronous pins.
//   clock_12mhz : destination clock
//   reset_n     : asynchronous active-low reset, both flops load RESET_VALUE
//   d           : asynchronous input
//   q           : synchronized output (two clock_12mhz cycles of latency)
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock_12mhz,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// button_debounce: synchronizes and debounces a raw push-button pin.
//   clock_12mhz   : system clock, 12 MHz
//   reset_n       : asynchronous active-low reset
//   button_raw    : raw pin, asynchronous to clock_12mhz
//   button_level  : debounced state, 1 = pressed
//   press_pulse   : one-cycle strobe on an accepted press
//   release_pulse : one-cycle strobe on an accepted release
//   long_pulse    : one-cycle strobe once a press has been held LONG_CYCLES
//                   (only with BUTTON_LONG_PRESS_EN defined, otherwise 0)
//   press_count   : accepted presses, modulo 256
// Build option: BUTTON_LONG_PRESS_EN enables the long-press counter.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_12MHZ,
  parameter int unsigned LONG_CYCLES     = LONG_1S_12MHZ,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                     clock_12mhz,
  input  logic                     reset_n,
  input  logic                     button_raw,
  output logic                     button_level,
  output logic                     press_pulse,
  output logic                     release_pulse,
  output logic                     long_pulse,
  output logic [PRESS_COUNT_W-1:0] press_count
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  button_state_t state;
  logic [DW-1:0] deb_cnt;
  logic          pressed_raw;
  logic          s;

  // Normalise polarity before synchronizing so reset value 0 is "released".
  assign pressed_raw = button_raw ^ ACTIVE_LOW;

  sync_2ff #(
    .RESET_VALUE(1'b0)
  ) u_sync (
    .clock_12mhz(clock_12mhz),
    .reset_n    (reset_n),
    .d          (pressed_raw),
    .q          (s)
  );

`ifdef BUTTON_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] long_cnt;
  logic          long_done;
`else
  assign long_pulse = 1'b0;
`endif

  always_ff @(posedge clock_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RELEASED;
      deb_cnt       <= '0;
      button_level  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= '0;
`ifdef BUTTON_LONG_PRESS_EN
      long_cnt      <= '0;
      long_done     <= 1'b0;
      long_pulse    <= 1'b0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
      long_pulse    <= 1'b0;
`endif
      case (state)
        RELEASED: begin
          if (s) begin
            state   <= PRESS_WAIT;
            deb_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= RELEASED;
          end else if (deb_cnt == DEB_LAST) begin
            state        <= PRESSED;
            press_pulse  <= 1'b1;
            button_level <= 1'b1;
            press_count  <= press_count + PRESS_COUNT_W'(1);
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            state   <= RELEASE_WAIT;
            deb_cnt <= '0;
          end
`ifdef BUTTON_LONG_PRESS_EN
          // Counter parks at LONG_LAST; long_done blocks repeats until release.
          else if (!long_done) begin
            if (long_cnt == LONG_LAST) begin
              long_pulse <= 1'b1;
              long_done  <= 1'b1;
            end else begin
              long_cnt <= long_cnt + LW'(1);
            end
          end
`endif
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            state         <= RELEASED;
            release_pulse <= 1'b1;
            button_level  <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
            long_cnt      <= '0;
            long_done     <= 1'b0;
`endif
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Input-side counterpart to the board's LED output logic. Reads a raw, bouncy, asynchronous push-button pin and synchronizes it to clock_12mhz.
- Debounces the pin with a stable-time counter and produces a clean level, one-cycle press/release/long-press events and a running press count.
- Sits between the board button pin and the LED sequencing logic. LED state machines advance on press_pulse instead of a free-running timer.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive synchronized-stable cycles required to accept a change (10 ms at 12 MHz); must be >= 2
- LONG_CYCLES, 12000000, cycles held in PRESSED before long_pulse fires (1 s at 12 MHz); must be >= 2
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (pull-up board); 0 = pin reads 1 when pressed

Ports:
- clock_12mhz  input  1  system clock, 12 MHz
- reset_n  input  1  asynchronous active-low reset
- button_raw  input  1  raw pin, asynchronous to clock_12mhz
- button_level  output  1  debounced state, 1 = pressed
- press_pulse  output  1  one-cycle strobe on accepted press
- release_pulse  output  1  one-cycle strobe on accepted release
- long_pulse  output  1  one-cycle strobe when a press has been held LONG_CYCLES
- press_count  output  8  accepted presses, modulo 256

Behaviour:
- Interface: one clock, clock_12mhz. Reset reset_n is asynchronous and active-low.
- Reset values:
  - all outputs 0; state RELEASED; all counters 0.
  - sync flops reset to the released level, so the post-polarity sample s = 0.
- Polarity: p = button_raw XOR ACTIVE_LOW, so p = 1 means pressed. p passes through a 2-flop synchronizer to give s.
- FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. All outputs are registered.
  - RELEASED: s=1 -> PRESS_WAIT, deb_cnt <= 0.
  - PRESS_WAIT:
    - s=0 -> RELEASED (glitch rejected, no event).
    - s=1 and deb_cnt == DEBOUNCE_CYCLES-1 -> PRESSED; press_pulse <= 1; button_level <= 1; press_count <= press_count+1.
    - else deb_cnt++.
  - PRESSED: s=0 -> RELEASE_WAIT, deb_cnt <= 0. Otherwise the long counter runs (see Optional Feature).
  - RELEASE_WAIT:
    - s=1 -> PRESSED (glitch rejected; long counter not cleared).
    - s=0 and deb_cnt == DEBOUNCE_CYCLES-1 -> RELEASED; release_pulse <= 1; button_level <= 0; long counter cleared.
    - else deb_cnt++.
- Pulses: press_pulse, release_pulse and long_pulse are high for exactly one cycle per event.
- Latency: raw goes to pressed and holds, first sampled at edge 0 -> press_pulse high in the cycle after edge DEBOUNCE_CYCLES+2. Release latency is identical.
- Width rules:
  - deb_cnt width = clog2(DEBOUNCE_CYCLES).
  - press_count wraps 255 -> 0 with no flag.
- Bounce: any s toggle during a WAIT state restarts qualification from 0 on the next attempt. A bouncing pin never produces more than one press_pulse per accepted press.
- Reset mid-operation: asserting reset_n low at any time clears everything immediately, with no pulse emitted. Button held across reset release -> treated as a new press; press_pulse follows after the normal latency.
- No simultaneous events are possible: press, release and long are mutually exclusive by state.

Optional Feature:
- Macro: BUTTON_LONG_PRESS_EN.
- Defined:
  - In PRESSED, long_cnt (width clog2(LONG_CYCLES)) increments each cycle.
  - At long_cnt == LONG_CYCLES-1, long_pulse fires once and long_cnt saturates; no repeat until release.
  - long_cnt clears on the accepted release and on reset.
- Undefined: long_pulse is tied to 0 and no long counter logic is instantiated.

Decomposition:
- Package button_pkg:
  - state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - default constants DEBOUNCE_10MS_12MHZ = 120000 and LONG_1S_12MHZ = 12000000;
  - PRESS_COUNT_W = 8.
- One sub-module: sync_2ff, a 1-bit 2-flop synchronizer with async active-low reset value parameter. It is reused for other pins.

Test Plan:
- Use DEBOUNCE_CYCLES=4 and LONG_CYCLES=10 for all scenarios.
- Reset with button_raw=1 (ACTIVE_LOW=1) -> all outputs 0. Hold 20 cycles -> no pulses, press_count=0.
- Clean press: raw 1->0 sampled at edge 0, held -> press_pulse high for exactly one cycle after edge 6, button_level=1, press_count=1. Release clean -> release_pulse one cycle after 6 edges, button_level=0.
- Bounce: raw toggles 0/1 every 2 cycles for 12 cycles, then stays 0 -> exactly one press_pulse, press_count=1.
- Long press (macro defined): hold 30 cycles -> exactly one long_pulse, 10 cycles after the cycle press_pulse was high. Macro undefined -> long_pulse stays 0.
- Reset mid-PRESS_WAIT: reset_n low 2 cycles while raw=0, release reset with raw still 0 -> no pulse during reset; press_pulse appears 6 edges after reset release. Also: 256 accepted presses -> press_count wraps to 0.
